// File: rtl/bp_be_pkg.sv
// Shared backend types for the aux-pipe arbiter and its in-flight tracker.
// Reservations carry their issue strobe in the MSB.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_tiny_cfg
  } bp_params_e;

  localparam int dpath_width_gp = 64;

  typedef enum logic [1:0] {
    e_aux_arb_run,
    e_aux_arb_drain,
    e_aux_arb_drained
  } aux_arb_state_e;

  typedef enum logic {
    e_aux_req0,
    e_aux_req1
  } aux_req_id_e;

  function automatic int bp_rsrv_width(bp_params_e cfg);
    return (cfg == e_bp_tiny_cfg) ? 24 : 40;
  endfunction

endpackage

// File: rtl/bp_be_aux_tracker.sv
// Shift register of {valid, id} following ops down the aux pipe.
// Flush kills every stage; count and next-cycle emptiness feed the arbiter.
module bp_be_aux_tracker
  import bp_be_pkg::*;
#(
  parameter int depth_p = 1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        flush_i,
  input  logic        v_i,
  input  aux_req_id_e id_i,
  output logic        v_o,
  output aux_req_id_e id_o,
  output logic        empty_next_o,
  output logic [2:0]  count_o
);

  logic [depth_p-1:0] v_r;
  logic [depth_p-1:0] id_r;
  logic               live;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r  <= '0;
      id_r <= '0;
    end else begin
      for (int i = depth_p - 1; i > 0; i--) begin
        v_r[i]  <= v_r[i-1] & ~flush_i;
        id_r[i] <= id_r[i-1];
      end
      v_r[0]  <= v_i & ~flush_i;
      id_r[0] <= id_i;
    end
  end

  assign v_o  = v_r[depth_p-1];
  assign id_o = aux_req_id_e'(id_r[depth_p-1]);

  // The last stage retires this edge, so only earlier stages survive.
  always_comb begin
    count_o = '0;
    live    = v_i;
    for (int i = 0; i < depth_p; i++) begin
      count_o = count_o + 3'(v_r[i]);
      if (i < depth_p - 1) live = live | v_r[i];
    end
    empty_next_o = flush_i | ~live;
  end

endmodule

// File: rtl/bp_be_aux_arbiter.sv
// Round-robin arbiter for two requesters sharing one aux pipe, with
// result routing, flush, drain handshake and sticky fflags accrual.
module bp_be_aux_arbiter
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int latency_p = 1,
  localparam int reservation_width_lp = bp_rsrv_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            req0_v_i,
  input  logic [reservation_width_lp-1:0] req0_reservation_i,
  output logic                            req0_ready_o,
  input  logic                            req1_v_i,
  input  logic [reservation_width_lp-1:0] req1_reservation_i,
  output logic                            req1_ready_o,
  output logic [reservation_width_lp-1:0] pipe_reservation_o,
  input  logic [dpath_width_gp-1:0]       pipe_data_i,
  input  logic [4:0]                      pipe_fflags_i,
  input  logic                            pipe_v_i,
  output logic                            resp0_v_o,
  output logic                            resp1_v_o,
  output logic [dpath_width_gp-1:0]       resp_data_o,
  output logic [4:0]                      resp_fflags_o,
  input  logic                            flush_i,
  input  logic                            drain_i,
  output logic                            drained_o,
  output logic [4:0]                      fflags_acc_o,
  input  logic                            fflags_clr_i,
  output logic [2:0]                      inflight_o
);

  localparam int v_bit_lp = reservation_width_lp - 1;

  aux_arb_state_e state_r, state_n;
  aux_req_id_e    ptr_r;
  aux_req_id_e    grant_id;
  aux_req_id_e    trk_id;
  logic           can_grant;
  logic           grant0, grant1, grant_v;
  logic           trk_v, trk_empty_next;
  logic           deliver;
  logic [4:0]     acc_r;

  // Ready looks only at the other requester's valid.
  assign can_grant = reset_n_i & (state_r == e_aux_arb_run)
                   & ~flush_i & ~drain_i;
  assign req0_ready_o = can_grant
                      & ((ptr_r == e_aux_req0) | ~req1_v_i);
  assign req1_ready_o = can_grant
                      & ((ptr_r == e_aux_req1) | ~req0_v_i);

  assign grant0   = req0_v_i & req0_ready_o;
  assign grant1   = req1_v_i & req1_ready_o;
  assign grant_v  = grant0 | grant1;
  assign grant_id = grant1 ? e_aux_req1 : e_aux_req0;

  always_comb begin
    pipe_reservation_o = grant1 ? req1_reservation_i
                                : req0_reservation_i;
    pipe_reservation_o[v_bit_lp] = grant_v;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_r <= e_aux_req0;
    else if (grant_v)
      ptr_r <= grant1 ? e_aux_req0 : e_aux_req1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_aux_arb_run;
    else state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_aux_arb_run:
        if (drain_i) state_n = e_aux_arb_drain;
      e_aux_arb_drain:
        if (!drain_i) state_n = e_aux_arb_run;
        else if (trk_empty_next) state_n = e_aux_arb_drained;
      e_aux_arb_drained:
        if (!drain_i) state_n = e_aux_arb_run;
      default: state_n = e_aux_arb_run;
    endcase
  end

  assign drained_o = (state_r == e_aux_arb_drained);

  bp_be_aux_tracker #(
    .depth_p(latency_p)
  ) u_tracker (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush_i),
    .v_i         (grant_v),
    .id_i        (grant_id),
    .v_o         (trk_v),
    .id_o        (trk_id),
    .empty_next_o(trk_empty_next),
    .count_o     (inflight_o)
  );

  assign deliver       = pipe_v_i & trk_v & ~flush_i;
  assign resp0_v_o     = deliver & (trk_id == e_aux_req0);
  assign resp1_v_o     = deliver & (trk_id == e_aux_req1);
  assign resp_data_o   = pipe_data_i;
  assign resp_fflags_o = pipe_fflags_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) acc_r <= '0;
    else if (fflags_clr_i) acc_r <= deliver ? pipe_fflags_i : '0;
    else if (deliver) acc_r <= acc_r | pipe_fflags_i;
  end

  assign fflags_acc_o = acc_r;

  a_untracked_result: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    pipe_v_i |-> (trk_v | flush_i));

endmodule

// File: tb/tb_bp_be_aux_arbiter.sv
// Bench for bp_be_aux_arbiter: latency 1 and latency 3 instances
// checked each cycle against a schedule-based reference model.
module tb_bp_be_aux_arbiter;
  import bp_be_pkg::*;

  localparam int RW = bp_rsrv_width(e_bp_default_cfg);
  localparam int DW = dpath_width_gp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          r0v [2];
  logic          r1v [2];
  logic [RW-1:0] r0r [2];
  logic [RW-1:0] r1r [2];
  logic          rdy0 [2];
  logic          rdy1 [2];
  logic [RW-1:0] prs [2];
  logic [DW-1:0] pd [2];
  logic [DW-1:0] rd [2];
  logic [4:0]    pf [2];
  logic [4:0]    rf [2];
  logic [4:0]    acc [2];
  logic          pv [2];
  logic          fl [2];
  logic          dr [2];
  logic          clr [2];
  logic          rsp0 [2];
  logic          rsp1 [2];
  logic          drd [2];
  logic [2:0]    infl [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bp_be_aux_arbiter #(
      .bp_params_p(e_bp_default_cfg),
      .latency_p  (g == 0 ? 1 : 3)
    ) u_dut (
      .clk_i             (clk),
      .reset_n_i         (rst_n),
      .req0_v_i          (r0v[g]),
      .req0_reservation_i(r0r[g]),
      .req0_ready_o      (rdy0[g]),
      .req1_v_i          (r1v[g]),
      .req1_reservation_i(r1r[g]),
      .req1_ready_o      (rdy1[g]),
      .pipe_reservation_o(prs[g]),
      .pipe_data_i       (pd[g]),
      .pipe_fflags_i     (pf[g]),
      .pipe_v_i          (pv[g]),
      .resp0_v_o         (rsp0[g]),
      .resp1_v_o         (rsp1[g]),
      .resp_data_o       (rd[g]),
      .resp_fflags_o     (rf[g]),
      .flush_i           (fl[g]),
      .drain_i           (dr[g]),
      .drained_o         (drd[g]),
      .fflags_acc_o      (acc[g]),
      .fflags_clr_i      (clr[g]),
      .inflight_o        (infl[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ptr_m [2];
  int st_m [2];
  int sched [2][8];
  logic [4:0] acc_m [2];
  logic [4:0] pfs [2];
  bit got0 [2];
  bit got1 [2];
  int waited;

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic string tg(string s, int d);
    return $sformatf("%s[L%0d]", s, lat(d));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      r0v[d] = 1'b0; r1v[d] = 1'b0;
      fl[d] = 1'b0; dr[d] = 1'b0; clr[d] = 1'b0;
      pv[d] = 1'b0; pfs[d] = '0; pf[d] = '0; pd[d] = '0;
      got0[d] = 1'b0; got1[d] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ptr_m[d] = 0; st_m[d] = 0; acc_m[d] = '0;
      for (int k = 0; k < 8; k++) sched[d][k] = -1;
    end
  endtask

  function automatic int pending(int d);
    int c;
    c = 0;
    for (int k = 0; k < 8; k++) if (sched[d][k] >= 0) c++;
    return c;
  endfunction

  // One clock: drive pipe results due now, check, advance the model.
  task automatic cycle();
    int gnt [2];
    int due [2];
    bit dlv [2];
    for (int d = 0; d < 2; d++) begin
      due[d] = sched[d][cyc % 8];
      pv[d] = (due[d] >= 0);
      pd[d] = {$urandom, $urandom};
      pf[d] = pfs[d];
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      bit can, e0, e1;
      logic [RW-1:0] exp_r;
      can = (st_m[d] == 0) && !fl[d] && !dr[d];
      e0 = can && !(r1v[d] && ptr_m[d] == 1);
      e1 = can && !(r0v[d] && ptr_m[d] == 0);
      gnt[d] = (r0v[d] && e0) ? 0 : (r1v[d] && e1) ? 1 : -1;
      dlv[d] = pv[d] && !fl[d];
      chk(tg("ready0", d), rdy0[d], e0);
      chk(tg("ready1", d), rdy1[d], e1);
      if (gnt[d] >= 0) begin
        exp_r = (gnt[d] == 0) ? r0r[d] : r1r[d];
        exp_r[RW-1] = 1'b1;
        chk(tg("pipe_rsrv", d), prs[d], exp_r);
      end else begin
        chk(tg("pipe_v", d), prs[d][RW-1], 0);
      end
      chk(tg("resp0", d), rsp0[d], dlv[d] && due[d] == 0);
      chk(tg("resp1", d), rsp1[d], dlv[d] && due[d] == 1);
      chk(tg("resp_data", d), rd[d], pd[d]);
      chk(tg("resp_fflags", d), rf[d], pf[d]);
      chk(tg("inflight", d), infl[d], pending(d));
      chk(tg("drained", d), drd[d], st_m[d] == 2);
      chk(tg("fflags_acc", d), acc[d], acc_m[d]);
    end
    for (int d = 0; d < 2; d++) begin
      got0[d] = (gnt[d] == 0);
      got1[d] = (gnt[d] == 1);
      if (dlv[d]) acc_m[d] = clr[d] ? pf[d] : (acc_m[d] | pf[d]);
      else if (clr[d]) acc_m[d] = '0;
      sched[d][cyc % 8] = -1;
      if (fl[d]) for (int k = 0; k < 8; k++) sched[d][k] = -1;
      if (gnt[d] >= 0) begin
        sched[d][(cyc + lat(d)) % 8] = gnt[d];
        ptr_m[d] = 1 - gnt[d];
      end
      case (st_m[d])
        0: if (dr[d]) st_m[d] = 1;
        1: if (!dr[d]) st_m[d] = 0;
           else if (pending(d) == 0) st_m[d] = 2;
        default: if (!dr[d]) st_m[d] = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock.
  task automatic do_reset();
    for (int d = 0; d < 2; d++) pv[d] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(tg("rst_ready0", d), rdy0[d], 0);
      chk(tg("rst_ready1", d), rdy1[d], 0);
      chk(tg("rst_pipe_v", d), prs[d][RW-1], 0);
      chk(tg("rst_resp0", d), rsp0[d], 0);
      chk(tg("rst_resp1", d), rsp1[d], 0);
      chk(tg("rst_drained", d), drd[d], 0);
      chk(tg("rst_acc", d), acc[d], 0);
      chk(tg("rst_inflight", d), infl[d], 0);
    end
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [RW-1:0] rnd_rsrv();
    return RW'({$urandom, $urandom});
  endfunction

  initial begin
    idle();
    model_reset();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      r0v[d] = 1'b1; r1v[d] = 1'b1;
    end
    do_reset();

    // Both requesters held valid: grants alternate 0,1,0,1.
    for (int d = 0; d < 2; d++) begin
      r0v[d] = 1'b1; r0r[d] = rnd_rsrv();
      r1v[d] = 1'b1; r1r[d] = rnd_rsrv();
    end
    repeat (4) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        if (got0[d]) r0r[d] = rnd_rsrv();
        if (got1[d]) r1r[d] = rnd_rsrv();
      end
    end
    idle();
    repeat (3) cycle();

    // Flush kills a returning req1 op and its flags.
    r1v[0] = 1'b1; r1r[0] = rnd_rsrv();
    cycle();
    r1v[0] = 1'b0; fl[0] = 1'b1; pfs[0] = 5'h10;
    cycle();
    fl[0] = 1'b0; pfs[0] = '0;
    cycle();
    chk("acc_after_flush", acc[0], 5'h00);

    // Accrual then clear with concurrent flags.
    r0v[0] = 1'b1; r0r[0] = rnd_rsrv();
    cycle();
    r0r[0] = rnd_rsrv(); pfs[0] = 5'h01;
    cycle();
    r0v[0] = 1'b0; pfs[0] = 5'h04;
    cycle();
    pfs[0] = '0;
    chk("acc_accrue", acc[0], 5'h05);
    r0v[0] = 1'b1; r0r[0] = rnd_rsrv();
    cycle();
    r0v[0] = 1'b0; pfs[0] = 5'h02; clr[0] = 1'b1;
    cycle();
    clr[0] = 1'b0; pfs[0] = '0;
    chk("acc_clr_new", acc[0], 5'h02);

    // Latency 3: three grants then drain.
    r0v[1] = 1'b1; r0r[1] = rnd_rsrv();
    repeat (3) begin
      cycle();
      if (got0[1]) r0r[1] = rnd_rsrv();
    end
    chk("inflight_full", infl[1], 3);
    dr[1] = 1'b1;
    repeat (3) cycle();
    chk("drained_set", drd[1], 1);
    chk("drained_inflight", infl[1], 0);
    dr[1] = 1'b0;
    cycle();
    cycle();
    idle();
    repeat (3) cycle();

    // Reset with two ops in flight.
    r0v[1] = 1'b1; r0r[1] = rnd_rsrv();
    r1v[1] = 1'b1; r1r[1] = rnd_rsrv();
    cycle();
    if (got0[1]) r0v[1] = 1'b0;
    if (got1[1]) r1v[1] = 1'b0;
    cycle();
    chk("inflight_pre_rst", infl[1], 2);
    r0v[1] = 1'b1; r1v[1] = 1'b1;
    do_reset();
    repeat (4) cycle();

    // req0 must win within 2 cycles under continuous req1.
    r0v[0] = 1'b1; r0r[0] = rnd_rsrv();
    cycle();
    r1v[0] = 1'b1; r1r[0] = rnd_rsrv();
    r0r[0] = rnd_rsrv();
    waited = 0;
    do begin
      cycle();
      waited++;
      if (got1[0]) r1r[0] = rnd_rsrv();
    end while (!got0[0] && waited < 4);
    chk("req0_no_starve", waited <= 2, 1);
    idle();
    repeat (3) cycle();

    // Randomized traffic on both instances.
    repeat (800) begin
      for (int d = 0; d < 2; d++) begin
        if (!r0v[d] || got0[d]) begin
          r0v[d] = ($urandom_range(0, 3) != 0);
          r0r[d] = rnd_rsrv();
        end
        if (!r1v[d] || got1[d]) begin
          r1v[d] = ($urandom_range(0, 3) != 0);
          r1r[d] = rnd_rsrv();
        end
        fl[d] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 11) == 0) dr[d] = !dr[d];
        clr[d] = ($urandom_range(0, 7) == 0);
        pfs[d] = 5'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
